platform_ram_pipe: RTL and testbench
====================================

PLATFORM_RAM_PIPE -- requirements
Module: platform_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32. Word width; legal values are 8, 16, 32, 64 and 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12. Word-address width.
REQ-003 SHALL have parameter DEPTH, default 4096. Number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1. Accept-to-readdatavalid latency in enabled cycles; legal values are 1 and 2.
REQ-005 SHALL have parameter INIT_ZERO, default 1. When 1, the block zero-fills the whole array after every reset.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL provide ports as follows (name, direction, width, meaning):
- clk, in, 1: sole clock.
- reset, in, 1: async active-high reset.
- address, in, ADDR_WIDTH: word address.
- byteenable, in, DATA_WIDTH/8: byte lane enables for writes.
- chipselect, in, 1: slave select.
- read, in, 1: read request.
- write, in, 1: write request.
- writedata, in, DATA_WIDTH: write data.
- clken, in, 1: clock enable.
- reset_req, in, 1: reset-request hold.
- freeze, in, 1: write protect.
- readdata, out, DATA_WIDTH: read data.
- readdatavalid, out, 1: readdata qualifier.
- waitrequest, out, 1: request stall.
- init_busy, out, 1: zero-fill in progress.

Function
REQ-008 SHALL derive clocken = clken & ~reset_req; when clocken=0, no array access, pipeline stage or output register updates, except the init sweep (REQ-012).
REQ-009 SHALL assert waitrequest when init_busy=1 or clocken=0; otherwise waitrequest=0.
REQ-010 SHALL accept a request at a rising edge only when chipselect=1, read or write=1, and waitrequest=0.
REQ-011 SHALL implement FSM states INIT and READY. Reset enters INIT if INIT_ZERO=1, else READY. INIT goes to READY after the sweep writes word DEPTH-1.
REQ-012 SHALL, in INIT, write zero to word counter value 0..DEPTH-1, one word per clk edge regardless of clocken, so INIT lasts exactly DEPTH cycles; init_busy=1 only in INIT.
REQ-013 SHALL, on an accepted write, update only the byte lanes with byteenable=1; byteenable all zero leaves the word unchanged.
REQ-014 SHALL drop an accepted write (no array change) when freeze=1 or address>=DEPTH; the write is still consumed with no error indication.
REQ-015 SHALL, on an accepted read, return the word after READ_LATENCY enabled edges: readdatavalid=1 for exactly one cycle per accepted read, with in-order results.
REQ-016 SHALL return readdata=0 with readdatavalid=1 for a read with address>=DEPTH.
REQ-017 SHALL sustain one accepted read per cycle (fully pipelined); back-to-back reads produce back-to-back readdatavalid pulses.
REQ-018 SHALL, for a read accepted the edge after a write to the same address, return the newly written data; a same-edge read and write is not possible (REQ-019).
REQ-019 SHALL treat read=1 with write=1 as a write only; no readdatavalid is generated.
REQ-020 SHALL hold readdata at its last value when readdatavalid=0.
REQ-021 SHALL freeze in-flight reads while clocken=0 and resume them without loss or duplication when clocken returns to 1.

Reset
REQ-022 SHALL, while reset=1, force readdata=0, readdatavalid=0, waitrequest=1, flush the read pipeline, and set init_busy=INIT_ZERO.
REQ-023 SHALL restart the sweep from word 0 if reset asserts during INIT; array contents are not reset except by the sweep.
REQ-024 SHALL, with INIT_ZERO=0, deassert waitrequest in the first cycle after reset deasserts, provided clocken=1.

Verification
REQ-025 SHALL pass the init test (DATA_WIDTH=32, DEPTH=16, ADDR_WIDTH=5, INIT_ZERO=1): release reset, then init_busy=1 and waitrequest=1 for exactly 16 cycles; read of address 7 returns 0x00000000.
REQ-026 SHALL pass the byte-lane test: write 0xAABBCCDD to address 3 with byteenable=0xF, then 0x11223344 with byteenable=0x5, then read address 3; result is 0xAA22CC44.
REQ-027 SHALL pass the latency/pipeline test (READ_LATENCY=2): reads of addresses 0, 1, 2 issued on consecutive edges; readdatavalid is high on 3 consecutive cycles starting 2 cycles after the first accept, with data in order.
REQ-028 SHALL pass the stall test: drop clken for 3 cycles with one read in flight; waitrequest=1, readdatavalid stays 0 during the stall, and the read completes exactly once afterwards.
REQ-029 SHALL pass the protect/range test: with freeze=1, write 0x5 to address 4 and leave the stored value unchanged; a read of address 20 (>=DEPTH) returns 0 with readdatavalid=1.
REQ-030 SHALL pass the reset-mid-op test: assert reset with one read in flight and 8 cycles into INIT; readdatavalid never pulses for the flushed read, and INIT runs a full 16 cycles after release.

Source files
------------

// File: rtl/platform_ram_pipe.sv
// platform_ram_pipe
//    Single-clock word RAM slave with byte-lane writes, a 1- or 2-stage read
//    pipeline, a clock enable and an optional post-reset zero-fill sweep.
//
// Ports
//    clk            sole clock
//    reset          asynchronous, active-high
//    address        word address
//    byteenable     per-byte write enables
//    chipselect     slave select
//    read, write    request strobes (read+write together is a write)
//    writedata      write data
//    clken          clock enable
//    reset_req      forces the slave idle, like clken=0
//    freeze         drops writes
//    readdata       read data, held between valid pulses
//    readdatavalid  one pulse per accepted read, in order
//    waitrequest    request stall
//    init_busy      zero-fill sweep in progress
//
// FSM
//    state    | meaning
//    ST_INIT  | sweeping zeros into word init_cnt; all requests stalled
//    ST_READY | normal operation
module platform_ram_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int DEPTH        = 4096,
   parameter int READ_LATENCY = 1,
   parameter int INIT_ZERO    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     address,
   input  logic [DATA_WIDTH/8-1:0]   byteenable,
   input  logic                      chipselect,
   input  logic                      read,
   input  logic                      write,
   input  logic [DATA_WIDTH-1:0]     writedata,
   input  logic                      clken,
   input  logic                      reset_req,
   input  logic                      freeze,
   output logic [DATA_WIDTH-1:0]     readdata,
   output logic                      readdatavalid,
   output logic                      waitrequest,
   output logic                      init_busy
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        init_cnt;

   logic                    clocken;
   logic                    req_acc;
   logic                    wr_acc;
   logic                    rd_acc;
   logic                    in_range;
   logic                    sweep_en;
   logic [IDX_W-1:0]        idx;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    p1_valid;
   logic [DATA_WIDTH-1:0]   p1_data;
   logic                    rdv_q;
   logic [DATA_WIDTH-1:0]   rd_q;

   // ---------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------
   assign clocken     = clken & ~reset_req;
   assign waitrequest = reset | init_busy | ~clocken;
   assign req_acc     = chipselect & (read | write) & ~waitrequest;
   assign wr_acc      = req_acc & write;
   assign rd_acc      = req_acc & read & ~write;

   // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
   assign in_range    = ({1'b0, address} < DEPTH_C);
   assign idx         = address[IDX_W-1:0];
   assign sweep_en    = init_busy & ~reset;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         // The sweep ignores clken so INIT always lasts exactly DEPTH cycles.
         if (state == ST_INIT) begin
            init_cnt <= (init_cnt == LAST_IDX) ? '0 : init_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:  if (init_cnt == LAST_IDX) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = ST_READY;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------
   always_comb begin
      init_busy = 1'b0;
      if (state == ST_INIT) init_busy = 1'b1;
   end

   // ---------------------------------------------------------------
   // Storage array (no reset; only the sweep clears it)
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sweep_en) begin
         mem[init_cnt] <= '0;
      end else if (wr_acc && !freeze && in_range) begin
         for (int b = 0; b < BE_W; b++) begin
            if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

   assign rd_word = in_range ? mem[idx] : '0;

   // ---------------------------------------------------------------
   // Read pipeline; everything holds while clocken=0
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p1_valid <= 1'b0;
         p1_data  <= '0;
         rdv_q    <= 1'b0;
         rd_q     <= '0;
      end else if (clocken) begin
         if (READ_LATENCY == 2) begin
            p1_valid <= rd_acc;
            if (rd_acc) p1_data <= rd_word;
            rdv_q <= p1_valid;
            if (p1_valid) rd_q <= p1_data;
         end else begin
            p1_valid <= 1'b0;
            rdv_q    <= rd_acc;
            if (rd_acc) rd_q <= rd_word;
         end
      end
   end

   // A pending valid is masked during a stall and presented once clocken
   // returns, so a stalled consumer sees each result exactly once.
   assign readdatavalid = rdv_q & clocken;
   assign readdata      = rd_q;

endmodule

// File: tb/tb_platform_ram_pipe.sv
module tb_platform_ram_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  address;
   logic [3:0]  byteenable;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic        clken;
   logic        reset_req;
   logic        freeze;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;
   logic        init_busy;

   platform_ram_pipe #(
      .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(2), .INIT_ZERO(1)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .freeze(freeze), .readdata(readdata),
      .readdatavalid(readdatavalid), .waitrequest(waitrequest), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        frz;
      logic [4:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[18];
   logic [31:0] exp_q[$];
   int          tests  = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (readdatavalid) begin
            if (exp_q.size() == 0) begin
               tests++;
               errors++;
               $display("FAIL rdv_unexpected: got readdatavalid=1 data %0h, required no pulse", readdata);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", {32'h0, readdata}, {32'h0, e});
            end
         end
      end
   endtask

   task automatic idle();
      chipselect = 1'b0; read = 1'b0; write = 1'b0; freeze = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input vec_t v);
      int n = 0;
      chipselect = 1'b1; read = v.rd; write = v.wr; freeze = v.frz;
      address = v.addr; byteenable = v.be; writedata = v.wdata;
      @(negedge clk);
      while (waitrequest && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (waitrequest) begin
         tests++;
         errors++;
         $display("FAIL issue_timeout: got waitrequest=1 for 50 cycles, required 0");
      end
      @(posedge clk);
      if (v.rd && !v.wr) exp_q.push_back(v.exp);
      #1;
   endtask

   task automatic measure_init(input string name);
      int cnt = 0;
      logic wr_ok = 1'b1;
      @(negedge clk);
      while (init_busy && cnt < 64) begin
         cnt++;
         if (!waitrequest) wr_ok = 1'b0;
         @(negedge clk);
      end
      chk({name, "_len"}, 64'(cnt), 64'd16);
      chk({name, "_wait"}, {63'h0, wr_ok}, 64'd1);
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic frz,
                               input logic [4:0] a, input logic [3:0] be,
                               input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.rd = rd; v.wr = wr; v.frz = frz; v.addr = a; v.be = be; v.wdata = d; v.exp = e;
      return v;
   endfunction

   initial begin
      int vcnt;

      vecs[0]  = mk(0, 1, 0, 5'd3,  4'hF, 32'hAABBCCDD, 32'h0);
      vecs[1]  = mk(0, 1, 0, 5'd3,  4'h5, 32'h11223344, 32'h0);
      vecs[2]  = mk(1, 0, 0, 5'd3,  4'h0, 32'h0,        32'hAA22CC44);
      vecs[3]  = mk(1, 0, 0, 5'd7,  4'h0, 32'h0,        32'h00000000);
      vecs[4]  = mk(0, 1, 1, 5'd4,  4'hF, 32'h00000005, 32'h0);
      vecs[5]  = mk(1, 0, 0, 5'd4,  4'h0, 32'h0,        32'h00000000);
      vecs[6]  = mk(0, 1, 0, 5'd4,  4'hF, 32'h12345678, 32'h0);
      vecs[7]  = mk(1, 0, 0, 5'd4,  4'h0, 32'h0,        32'h12345678);
      vecs[8]  = mk(1, 0, 0, 5'd20, 4'h0, 32'h0,        32'h00000000);
      vecs[9]  = mk(0, 1, 0, 5'd20, 4'hF, 32'hFFFFFFFF, 32'h0);
      vecs[10] = mk(1, 0, 0, 5'd4,  4'h0, 32'h0,        32'h12345678);
      vecs[11] = mk(1, 1, 0, 5'd5,  4'h3, 32'hCAFEF00D, 32'h0);
      vecs[12] = mk(1, 0, 0, 5'd5,  4'h0, 32'h0,        32'h0000F00D);
      vecs[13] = mk(0, 1, 0, 5'd0,  4'h0, 32'hFFFFFFFF, 32'h0);
      vecs[14] = mk(1, 0, 0, 5'd0,  4'h0, 32'h0,        32'h00000000);
      vecs[15] = mk(0, 1, 0, 5'd15, 4'h8, 32'h9A000000, 32'h0);
      vecs[16] = mk(1, 0, 0, 5'd15, 4'h0, 32'h0,        32'h9A000000);
      vecs[17] = mk(1, 0, 0, 5'd16, 4'h0, 32'h0,        32'h00000000);

      reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
      address = '0; byteenable = '0; writedata = '0;
      idle();
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_readdata", {32'h0, readdata}, 64'd0);
      chk("rst_rdv", {63'h0, readdatavalid}, 64'd0);
      chk("rst_wait", {63'h0, waitrequest}, 64'd1);
      chk("rst_busy", {63'h0, init_busy}, 64'd1);

      // Initial sweep
      @(posedge clk); #1;
      reset = 1'b0;
      measure_init("init");
      @(posedge clk); #1;

      // Table vectors, back to back
      for (int i = 0; i < 18; i++) issue(vecs[i]);
      idle();
      repeat (4) @(posedge clk);
      #1;

      // Pipelined reads of 0,1,2 on consecutive edges
      issue(mk(0, 1, 0, 5'd0, 4'hF, 32'h10101010, 32'h0));
      issue(mk(0, 1, 0, 5'd1, 4'hF, 32'h21212121, 32'h0));
      issue(mk(0, 1, 0, 5'd2, 4'hF, 32'h32323232, 32'h0));
      idle();
      repeat (4) @(posedge clk);
      #1;
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 5'd0;
      @(negedge clk);
      chk("pipe_wait", {63'h0, waitrequest}, 64'd0);
      chk("pipe_v0", {63'h0, readdatavalid}, 64'd0);
      @(posedge clk); exp_q.push_back(32'h10101010); #1;
      address = 5'd1;
      @(negedge clk);
      chk("pipe_v1", {63'h0, readdatavalid}, 64'd0);
      @(posedge clk); exp_q.push_back(32'h21212121); #1;
      address = 5'd2;
      @(negedge clk);
      chk("pipe_v2", {63'h0, readdatavalid}, 64'd1);
      @(posedge clk); exp_q.push_back(32'h32323232); #1;
      idle();
      @(negedge clk);
      chk("pipe_v3", {63'h0, readdatavalid}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk("pipe_v4", {63'h0, readdatavalid}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk("pipe_v5", {63'h0, readdatavalid}, 64'd0);
      @(posedge clk); #1;

      // Stall with one read in flight
      issue(mk(1, 0, 0, 5'd3, 4'h0, 32'h0, 32'hAA22CC44));
      idle();
      clken = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("stall_wait", {63'h0, waitrequest}, 64'd1);
         chk("stall_rdv", {63'h0, readdatavalid}, 64'd0);
         @(posedge clk);
      end
      #1;
      clken = 1'b1;
      vcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (readdatavalid) vcnt++;
      end
      chk("stall_once", 64'(vcnt), 64'd1);

      // reset_req stalls requests
      @(posedge clk); #1;
      reset_req = 1'b1;
      chipselect = 1'b1; read = 1'b1; address = 5'd3;
      @(negedge clk);
      chk("rreq_wait", {63'h0, waitrequest}, 64'd1);
      repeat (2) @(posedge clk);
      #1;
      idle();
      reset_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset with a read in flight, then again 8 cycles into INIT
      issue(mk(1, 0, 0, 5'd3, 4'h0, 32'h0, 32'hAA22CC44));
      idle();
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rdv", {63'h0, readdatavalid}, 64'd0);
      chk("mid_wait", {63'h0, waitrequest}, 64'd1);
      chk("mid_readdata", {32'h0, readdata}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_busy8", {63'h0, init_busy}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_busy_rst", {63'h0, init_busy}, 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      measure_init("reinit");
      @(posedge clk); #1;
      issue(mk(1, 0, 0, 5'd3, 4'h0, 32'h0, 32'h00000000));
      issue(mk(1, 0, 0, 5'd4, 4'h0, 32'h0, 32'h00000000));
      idle();
      repeat (6) @(posedge clk);
      #1;
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
